// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

  // Scan phases: all digits dark, or one digit lit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Active-low segment bus value with every segment off.
  localparam logic [6:0] DISP_OFF = 7'h7F;

  // Default scan timing.
  localparam int DEF_N_DIGITS     = 4;
  localparam int DEF_DWELL_CYCLES = 50000;
  localparam int DEF_BLANK_CYCLES = 500;

  // Width of a timer that must count up to the longer of the two phases.
  // Never narrower than one bit, so single-cycle phases still elaborate.
  function automatic int timer_width(input int dwell, input int blank);
    int longest;
    longest = (dwell > blank) ? dwell : blank;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/DisplayDecoder.sv
// Hex code to 7-segment glyph decoder, active-high segments ordered {g..a}.
module DisplayDecoder (
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Glyph lookup for codes 0..F.
  always_comb begin
    seg = 7'h00;
    case (code)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Round-robin scanner for a common-segment multi-digit 7-segment display.
// Each digit slot is a blanking gap followed by a dwell period; all outputs
// are registered and reflect the scan state of the previous cycle.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        enable_i,
  input  logic                        wr_en_i,
  input  logic [$clog2(N_DIGITS)-1:0] wr_addr_i,
  input  logic [3:0]                  wr_data_i,
  input  logic [N_DIGITS-1:0]         mask_i,
  output logic [N_DIGITS-1:0]         dig_n_o,
  output logic [6:0]                  display_n_o,
  output logic                        frame_o
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int TMR_W = timer_width(DWELL_CYCLES, BLANK_CYCLES);

  localparam logic [TMR_W-1:0] DWELL_LAST = TMR_W'(DWELL_CYCLES - 1);
  localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W:0]   ADDR_LIMIT = (IDX_W + 1)'(N_DIGITS);

  localparam logic [TMR_W-1:0]    TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [IDX_W-1:0]    IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{1'b1}};

  scan_state_t      state_r, state_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic [IDX_W-1:0] idx_r, idx_s;

  logic [3:0] digit_r [N_DIGITS];

  logic [3:0]          cur_code_s;
  logic [6:0]          seg_s;
  logic [N_DIGITS-1:0] dig_n_s, dig_n_r;
  logic [6:0]          display_n_s, display_n_r;
  logic                frame_s, frame_r;
  logic                wr_hit_s;

  // Code of the digit the scan currently points at, fed to the glyph decoder.
  assign cur_code_s = digit_r[idx_r];

  DisplayDecoder u_decoder (
    .code (cur_code_s),
    .seg  (seg_s)
  );

  // Writes beyond the populated digits are dropped.
  assign wr_hit_s = wr_en_i && ({1'b0, wr_addr_i} < ADDR_LIMIT);

  // Digit code storage; kept across enable changes, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        digit_r[i] <= 4'h0;
      end
    end else if (wr_hit_s) begin
      digit_r[wr_addr_i] <= wr_data_i;
    end
  end

  // Scan state, phase timer and digit index registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= BLANK;
      timer_r <= TMR_ZERO;
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state logic: blank gap, then dwell, then advance to the next digit.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    idx_s   = idx_r;
    if (!enable_i) begin
      state_s = BLANK;
      timer_s = TMR_ZERO;
      idx_s   = IDX_ZERO;
    end else begin
      case (state_r)
        BLANK: begin
          if (timer_r == BLANK_LAST) begin
            state_s = SHOW;
            timer_s = TMR_ZERO;
          end else begin
            timer_s = timer_r + TMR_W'(1'b1);
          end
        end
        SHOW: begin
          if (timer_r == DWELL_LAST) begin
            state_s = BLANK;
            timer_s = TMR_ZERO;
            idx_s   = (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IDX_W'(1'b1);
          end else begin
            timer_s = timer_r + TMR_W'(1'b1);
          end
        end
        default: begin
          state_s = BLANK;
          timer_s = TMR_ZERO;
          idx_s   = IDX_ZERO;
        end
      endcase
    end
  end

  // Output decode from the current state; a masked digit still uses its slot.
  always_comb begin
    dig_n_s     = DIG_OFF;
    display_n_s = DISP_OFF;
    frame_s     = 1'b0;
    if (enable_i) begin
      if ((state_r == SHOW) && !mask_i[idx_r]) begin
        dig_n_s[idx_r] = 1'b0;
        display_n_s    = ~seg_s;
      end else begin
        dig_n_s     = DIG_OFF;
        display_n_s = DISP_OFF;
      end
      // First cycle of the gap ahead of digit 0 marks a new frame.
      frame_s = (state_r == BLANK) && (timer_r == TMR_ZERO) && (idx_r == IDX_ZERO);
    end else begin
      dig_n_s     = DIG_OFF;
      display_n_s = DISP_OFF;
      frame_s     = 1'b0;
    end
  end

  // Output registers; reset darkens the display without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dig_n_r     <= DIG_OFF;
      display_n_r <= DISP_OFF;
      frame_r     <= 1'b0;
    end else begin
      dig_n_r     <= dig_n_s;
      display_n_r <= display_n_s;
      frame_r     <= frame_s;
    end
  end

  assign dig_n_o     = dig_n_r;
  assign display_n_o = display_n_r;
  assign frame_o     = frame_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a 4-digit and a 3-digit instance share stimulus
// and are compared every cycle against a slot-arithmetic reference model.
module tb_display_scan_ctrl;

  localparam int DW   = 4;
  localparam int BL   = 2;
  localparam int SLOT = DW + BL;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       enable  = 1'b0;
  logic       wr_en   = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'd0;
  logic [3:0] mask    = 4'd0;

  logic [3:0] dig4;
  logic [6:0] seg4;
  logic       fr4;
  logic [2:0] dig3;
  logic [6:0] seg3;
  logic       fr3;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state: pos = enabled edges since the last restart.
  int         pos = 0;
  logic [3:0] md4 [4];
  logic [3:0] md3 [3];
  logic [3:0] e_dig4;
  logic [6:0] e_seg4;
  logic       e_fr4;
  logic [2:0] e_dig3;
  logic [6:0] e_seg3;
  logic       e_fr3;

  always #5 clk = ~clk;

  display_scan_ctrl #(.N_DIGITS(4), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut4 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .enable_i    (enable),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .mask_i      (mask),
    .dig_n_o     (dig4),
    .display_n_o (seg4),
    .frame_o     (fr4)
  );

  display_scan_ctrl #(.N_DIGITS(3), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut3 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .enable_i    (enable),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .mask_i      (mask[2:0]),
    .dig_n_o     (dig3),
    .display_n_o (seg3),
    .frame_o     (fr3)
  );

  // Standard hex glyphs, active-high {g..a}.
  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  // Expected outputs for the edge just taken, then apply that edge's write.
  task automatic model_edge();
    int w;
    int s4;
    int s3;
    e_dig4 = 4'hF; e_seg4 = 7'h7F; e_fr4 = 1'b0;
    e_dig3 = 3'h7; e_seg3 = 7'h7F; e_fr3 = 1'b0;
    if (!enable) begin
      pos = 0;
    end else begin
      w  = pos % SLOT;
      s4 = (pos / SLOT) % 4;
      s3 = (pos / SLOT) % 3;
      if (w >= BL && !mask[s4]) begin
        e_dig4[s4] = 1'b0;
        e_seg4     = ~glyph(md4[s4]);
      end
      if (w >= BL && !mask[s3]) begin
        e_dig3[s3] = 1'b0;
        e_seg3     = ~glyph(md3[s3]);
      end
      e_fr4 = ((pos % (SLOT * 4)) == 0);
      e_fr3 = ((pos % (SLOT * 3)) == 0);
      pos++;
    end
    if (wr_en) begin
      md4[wr_addr] = wr_data;
      if (int'(wr_addr) < 3) md3[wr_addr] = wr_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("dig4", {4'd0, dig4}, {4'd0, e_dig4});
    chk("seg4", {1'b0, seg4}, {1'b0, e_seg4});
    chk("frame4", {7'd0, fr4}, {7'd0, e_fr4});
    chk("dig3", {5'd0, dig3}, {5'd0, e_dig3});
    chk("seg3", {1'b0, seg3}, {1'b0, e_seg3});
    chk("frame3", {7'd0, fr3}, {7'd0, e_fr3});
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_dig4"}, {4'd0, dig4}, 8'h0F);
    chk({tag, "_seg4"}, {1'b0, seg4}, 8'h7F);
    chk({tag, "_fr4"}, {7'd0, fr4}, 8'h00);
    chk({tag, "_dig3"}, {5'd0, dig3}, 8'h07);
    chk({tag, "_seg3"}, {1'b0, seg3}, 8'h7F);
    chk({tag, "_fr3"}, {7'd0, fr3}, 8'h00);
  endtask

  task automatic model_clear();
    pos = 0;
    for (int i = 0; i < 4; i++) md4[i] = 4'd0;
    for (int i = 0; i < 3; i++) md3[i] = 4'd0;
  endtask

  // At most one digit enable may be low in any cycle.
  always @(negedge clk) begin
    ntests++;
    assert ($countones(~dig4) <= 1 && $countones(~dig3) <= 1) else begin
      nfail++;
      $error("FAIL onehot: observed dig4 %b dig3 %b expected at most one low", dig4, dig3);
    end
  end

  initial begin
    model_clear();

    // Asynchronous reset with no clock edge in between.
    #2 rst_n = 1'b0;
    #1 chk_dark("reset");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Codes 1..4 into addresses 0..3; address 3 does not exist on the 3-digit build.
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = 2'(i);
      wr_data = 4'(i + 1);
      step();
    end
    wr_en = 1'b0;
    repeat (56) step();

    // Digit 1 masked: its slot stays dark, frame timing unchanged.
    mask = 4'b0010;
    repeat (48) step();
    mask = 4'b0000;

    // Overwrite digit 2 while it is lit.
    for (int k = 0; k < 30 && (pos % 24) != 15; k++) step();
    chk("sync_wr", {7'd0, ((pos % 24) == 15)}, 8'h01);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd9;
    step();
    wr_en = 1'b0;
    repeat (8) step();

    // Drop enable during digit 2's dwell, then restart.
    for (int k = 0; k < 30 && (pos % 24) != 15; k++) step();
    chk("sync_en", {7'd0, ((pos % 24) == 15)}, 8'h01);
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    repeat (30) step();

    // Randomized writes, mask changes and enable drops.
    for (int r = 0; r < 400; r++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom);
      wr_data = 4'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      step();
    end
    wr_en  = 1'b0;
    mask   = 4'b0000;
    enable = 1'b1;

    // Reset in the middle of a dwell.
    for (int k = 0; k < 20 && (pos % SLOT) != 4; k++) step();
    chk("sync_rst", {7'd0, ((pos % SLOT) == 4)}, 8'h01);
    #2 rst_n = 1'b0;
    #1 chk_dark("midrst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexing controller for a common-segment 4-digit 7-segment display.
- Holds one 4-bit code per digit, written by the surrounding logic (counters, button handlers).
- Scans the digits round-robin, with a blanking gap between digits to prevent ghosting.
- Drives the shared active-low segment bus through the existing DisplayDecoder.

Parameters:
N_DIGITS, 4, number of digits scanned (2..8).
DWELL_CYCLES, 50000, clock cycles each digit is lit per scan slot (>=1).
BLANK_CYCLES, 500, clock cycles all digits are off between slots (>=1).

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  1 = scanning runs; 0 = display dark, scan halted
wr_en_i  in  1  write strobe for a digit code
wr_addr_i  in  $clog2(N_DIGITS)  digit index to write
wr_data_i  in  4  code to store
mask_i  in  N_DIGITS  bit i = 1 keeps digit i dark in its slot
dig_n_o  out  N_DIGITS  active-low digit enables, at most one low
display_n_o  out  7  active-low segments {g..a}
frame_o  out  1  one-cycle pulse at the start of each full scan

Behaviour:
- Interface: one clock (clk_i); reset rst_n_i is asynchronous and active-low.
- Reset values:
  - digit registers = 0, scan index = 0, state = BLANK, timer = 0;
  - dig_n_o = all 1, display_n_o = 7'h7F, frame_o = 0.
- FSM states: BLANK, SHOW.
  - BLANK → SHOW when timer == BLANK_CYCLES-1. Timer clears.
  - SHOW → BLANK when timer == DWELL_CYCLES-1. Timer clears; index increments, wrapping N_DIGITS-1 → 0.
  - Otherwise the timer increments each cycle.
- Slot length is DWELL_CYCLES+BLANK_CYCLES cycles; a frame is N_DIGITS slots.
- Output registers are updated every cycle:
  - In BLANK: dig_n_o = all 1, display_n_o = 7'h7F.
  - In SHOW with mask_i[idx] = 0: dig_n_o[idx] = 0, all other bits 1; display_n_o = ~decode(digit_reg[idx]).
  - In SHOW with mask_i[idx] = 1: outputs stay dark, but the slot time is still consumed so brightness stays uniform.
  - Outputs lag the internal state by exactly one cycle.
- frame_o is registered. It is 1 for the single cycle in which the outputs enter the BLANK that precedes index 0's SHOW. The first BLANK after reset counts.
- Writes:
  - On a clock edge with wr_en_i = 1 and wr_addr_i < N_DIGITS, digit_reg[wr_addr_i] takes wr_data_i.
  - Addresses >= N_DIGITS are ignored.
  - A write to the digit currently shown appears on display_n_o one cycle after the write edge, with no glitch to other digits.
- Codes 10..15 are passed to DisplayDecoder unmodified; their glyphs are whatever it defines.
- enable_i = 0 (sampled synchronously):
  - state forced to BLANK, timer = 0, index = 0, outputs dark next cycle, frame_o = 0;
  - digit registers keep their values, and writes are still accepted.
- On enable_i 0 → 1, scanning restarts from BLANK at index 0, and frame_o pulses as it does after reset.
- mask_i is sampled every cycle. A change mid-SHOW takes effect on the next cycle's outputs.
- Reset asserted mid-slot returns all state to its reset values immediately; outputs go dark without waiting for a clock.
- Invariant: dig_n_o never has more than one bit low, including across state changes.

Decomposition:
- Shared package display_pkg holds:
  - scan_state_t enum {BLANK, SHOW};
  - DISP_OFF = 7'h7F;
  - the default timing constants.
- Sub-module: the existing DisplayDecoder, instantiated once on the selected digit's code. No new sub-module.
- Timer width is $clog2(max(DWELL_CYCLES, BLANK_CYCLES)).

Test Plan:
All scenarios use N_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
1. Reset, then write codes 1,2,3,4 to addresses 0..3 with enable_i=1 → each digit is lit for 4 cycles with dig_n_o = 1110, 1101, 1011, 0111 in turn, segments matching decode(1..4), 2 dark cycles between digits, frame_o period 24 cycles.
2. mask_i = 4'b0010 → digit 1's slot is dark for all 6 cycles, the other digits are unchanged, and the frame period stays 24.
3. Write 9 to address 2 in the 2nd cycle of digit 2's SHOW → display_n_o changes to ~decode(9) on the next cycle while dig_n_o stays 1011.
4. wr_addr_i = 3 for N_DIGITS=3 (separate build) → all digit registers are unchanged.
5. Drop enable_i mid-SHOW of digit 2 for 10 cycles, then raise it → dark from the next cycle; on re-enable, 2 BLANK cycles with frame_o pulsing, then digit 0 is shown first.
6. Assert rst_n_i asynchronously mid-SHOW → dig_n_o = 1111 and display_n_o = 7F before the next clock edge; digit registers read 0 afterwards. A checker asserts at most one dig_n_o bit low in every cycle of every test.
